tx_crc_serializer: RTL and testbench

Single-clock reply serializer for the tag transmit path. Loads a right-aligned reply word of 0–32 bits, shifts it out MSB-first to the downstream modulator over a valid/ready bit handshake, and optionally appends the EPC Gen2 CRC-16 computed on the fly over the transmitted data bits. It sits between the reply-assembly logic and the backscatter modulator. It replaces the dual-clock generate/readout CRC arrangement with a single synchronous datapath.

---
 rtl/tx_crc_serializer_if.sv | 32 +++
 rtl/tx_crc_serializer.sv | 111 +++++++++++
 tb/tb_tx_crc_serializer.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tx_crc_serializer_if.sv
// tx_crc_serializer_if
// Bundles the frame-load controls and the bit handshake of the reply serializer.
//   start, data, len, crc_en, abort : frame request from reply assembly
//   bit_ready                       : modulator accepts the current bit
//   bit_out, bit_valid              : serial bit stream to the modulator
//   busy, done                      : transfer status back to reply assembly
// The master modport is the environment around the serializer: reply assembly
// and modulator together. The slave modport is the serializer.
interface tx_crc_serializer_if #(
  parameter int MAXLEN = 32
);
  logic              start;
  logic [MAXLEN-1:0] data;
  logic [5:0]        len;
  logic              crc_en;
  logic              abort;
  logic              bit_ready;
  logic              bit_out;
  logic              bit_valid;
  logic              busy;
  logic              done;

  modport master (
    output start, data, len, crc_en, abort, bit_ready,
    input  bit_out, bit_valid, busy, done
  );

  modport slave (
    input  start, data, len, crc_en, abort, bit_ready,
    output bit_out, bit_valid, busy, done
  );
endinterface

// File: rtl/tx_crc_serializer.sv
// tx_crc_serializer
// Shifts a right-aligned reply word (0..MAXLEN bits) out MSB-first over a
// valid/ready bit handshake and optionally appends the ones-complemented
// EPC Gen2 CRC-16 (poly 0x1021, preset 0xFFFF) computed over the sent bits.
// Ports:
//   clk     : sole clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : tx_crc_serializer_if.slave (load controls, bit stream, status)
module tx_crc_serializer #(
  parameter int MAXLEN = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  tx_crc_serializer_if.slave     bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DATA = 2'd1;
  localparam logic [1:0] S_CRC  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [5:0] LEN_MAX = 6'(MAXLEN);

  logic [1:0]        state;
  logic [15:0]       crc_q;
  logic [5:0]        cnt;
  logic [3:0]        crc_k;
  logic              crc_en_q;
  logic [MAXLEN-1:0] shreg;

  logic              in_data;
  logic              in_crc;
  logic              xfer;
  logic              load;
  logic [5:0]        len_c;

  // One serial step of the CRC-16 register for a transmitted bit.
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    logic fb;
    fb = b ^ c[15];
    return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  assign in_data = (state == S_DATA);
  assign in_crc  = (state == S_CRC);

  assign bus.bit_valid = in_data | in_crc;
  assign bus.busy      = in_data | in_crc;
  assign bus.done      = (state == S_DONE);

  // The CRC register is frozen during the CRC phase, so its bits are indexed
  // rather than shifted out.
  assign bus.bit_out = in_data ? shreg[MAXLEN-1] :
                       in_crc  ? ~crc_q[4'd15 - crc_k] : 1'b0;

  assign xfer  = bus.bit_valid & bus.bit_ready;
  assign load  = bus.start & ~bus.busy & ~bus.abort;
  assign len_c = (bus.len > LEN_MAX) ? LEN_MAX : bus.len;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      crc_q    <= 16'hFFFF;
      cnt      <= '0;
      crc_k    <= '0;
      crc_en_q <= 1'b0;
    end else if (bus.abort) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (load) begin
            crc_q    <= 16'hFFFF;
            cnt      <= len_c;
            crc_k    <= '0;
            crc_en_q <= bus.crc_en;
            if (len_c != 6'd0)   state <= S_DATA;
            else if (bus.crc_en) state <= S_CRC;
            else                 state <= S_DONE;
          end else begin
            state <= S_IDLE;
          end
        end
        S_DATA: begin
          if (xfer) begin
            crc_q <= crc_step(crc_q, shreg[MAXLEN-1]);
            cnt   <= cnt - 6'd1;
            if (cnt == 6'd1) state <= crc_en_q ? S_CRC : S_DONE;
          end
        end
        S_CRC: begin
          if (xfer) begin
            crc_k <= crc_k + 4'd1;
            if (crc_k == 4'd15) state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Payload is left-aligned on load so the next bit is always the MSB.
  always_ff @(posedge clk) begin
    if (load && (state == S_IDLE || state == S_DONE)) begin
      shreg <= bus.data << (LEN_MAX - len_c);
    end else if (xfer && in_data) begin
      shreg <= {shreg[MAXLEN-2:0], 1'b0};
    end
  end

endmodule

// File: tb/tb_tx_crc_serializer.sv
module tb_tx_crc_serializer;

  logic clk;
  logic reset_n;
  int   total;
  int   bad;

  tx_crc_serializer_if #(.MAXLEN(32)) bus ();

  tx_crc_serializer #(.MAXLEN(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: list of bits on the wire for a frame, from the frame rules.
  task automatic build_ref(input logic [31:0] d, input logic [5:0] l,
                           input logic c, output bit q[$]);
    int n;
    logic [15:0] r;
    q = {};
    n = (l > 6'd32) ? 32 : int'(l);
    r = 16'hFFFF;
    for (int i = n - 1; i >= 0; i--) begin
      q.push_back(d[i]);
      if (d[i] ^ r[15]) r = {r[14:0], 1'b0} ^ 16'h1021;
      else              r = {r[14:0], 1'b0};
    end
    if (c) for (int i = 15; i >= 0; i--) q.push_back(~r[i]);
  endtask

  // Called at a negedge with the DUT idle or in its DONE cycle; returns at
  // the negedge of the cycle in which done is observed.
  task automatic run_frame(input logic [31:0] d, input logic [5:0] l,
                           input logic c, input bit rnd, input bit poke,
                           output logic [63:0] got, output int ngot);
    bit q[$];
    int idx, cyc;
    bit stall, fin;
    logic prev;
    build_ref(d, l, c, q);
    got = '0; ngot = 0; idx = 0; cyc = 0; stall = 0; fin = 0; prev = 0;
    bus.data = d; bus.len = l; bus.crc_en = c; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.bit_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    while (!fin && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (idx == q.size()) begin
        total++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.bit_valid !== 1'b0) begin
          bad++;
          $display("FAIL done_pulse: got done=%b busy=%b valid=%b, want 1 0 0",
                   bus.done, bus.busy, bus.bit_valid);
        end
        fin = 1;
      end else begin
        total++;
        if (bus.bit_valid !== 1'b1 || bus.busy !== 1'b1) begin
          bad++;
          $display("FAIL valid_busy: got valid=%b busy=%b at bit %0d, want 1 1",
                   bus.bit_valid, bus.busy, idx);
        end
        if (stall) begin
          total++;
          if (bus.bit_out !== prev) begin
            bad++;
            $display("FAIL stall_hold: got %b, want %b", bus.bit_out, prev);
          end
        end
        if (bus.bit_ready) begin
          total++;
          if (bus.bit_out !== q[idx]) begin
            bad++;
            $display("FAIL bit[%0d]: got %b, want %b", idx, bus.bit_out, q[idx]);
          end
          got = {got[62:0], bus.bit_out};
          ngot++;
          idx++;
          stall = 0;
        end else begin
          stall = 1;
        end
        prev = bus.bit_out;
        @(posedge clk); #1;
        bus.bit_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (poke && cyc == 2) begin
          bus.start = 1'b1; bus.data = ~d; bus.len = 6'd5; bus.crc_en = ~c;
        end else begin
          bus.start = 1'b0;
        end
      end
    end
    bus.start = 1'b0;
    if (!fin) begin
      total++; bad++;
      $display("FAIL frame_timeout: got %0d bits, want %0d", idx, q.size());
    end
  endtask

  task automatic check_idle_after(input string nm);
    @(negedge clk);
    total++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.bit_valid !== 1'b0) begin
      bad++;
      $display("FAIL %s: got done=%b busy=%b valid=%b, want 0 0 0",
               nm, bus.done, bus.busy, bus.bit_valid);
    end
  endtask

  task automatic test_reset();
    logic [63:0] g; int n;
    reset_n = 1'b0;
    bus.start = 0; bus.data = '0; bus.len = '0; bus.crc_en = 0;
    bus.abort = 0; bus.bit_ready = 0;
    repeat (3) @(negedge clk);
    total++;
    if ({bus.bit_out, bus.bit_valid, bus.busy, bus.done} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_outputs: got %b, want 0000",
               {bus.bit_out, bus.bit_valid, bus.busy, bus.done});
    end
    reset_n = 1'b1;
    // Frame interrupted by reset mid-way.
    bus.data = 32'hFF; bus.len = 6'd8; bus.crc_en = 1; bus.bit_ready = 1; bus.start = 1;
    @(posedge clk); #1 bus.start = 0;
    @(posedge clk); #2;
    total++;
    if (bus.bit_valid !== 1'b1 || bus.bit_out !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset_frame: got valid=%b bit=%b, want 1 1", bus.bit_valid, bus.bit_out);
    end
    reset_n = 1'b0;
    #1;
    total++;
    if ({bus.bit_out, bus.bit_valid, bus.busy, bus.done} !== 4'b0000) begin
      bad++;
      $display("FAIL async_reset: got %b, want 0000",
               {bus.bit_out, bus.bit_valid, bus.busy, bus.done});
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    check_idle_after("post_reset_idle");
    run_frame(32'h3C, 6'd8, 1'b0, 1'b0, 1'b0, g, n);
    total++;
    if (n != 8 || g[7:0] !== 8'h3C) begin
      bad++;
      $display("FAIL post_reset_frame: got n=%0d bits=%0h, want 8 3c", n, g[7:0]);
    end
    check_idle_after("post_reset_done_len");
  endtask

  task automatic test_crc_zero_byte();
    logic [63:0] g; int n;
    run_frame(32'h0, 6'd8, 1'b1, 1'b0, 1'b0, g, n);
    total++;
    if (n != 24 || g[23:0] !== 24'h001E0F) begin
      bad++;
      $display("FAIL crc_zero_byte: got n=%0d bits=%06h, want 24 001e0f", n, g[23:0]);
    end
    check_idle_after("crc_zero_done_len");
  endtask

  task automatic test_crc_only();
    logic [63:0] g; int n;
    run_frame(32'hDEADBEEF, 6'd0, 1'b1, 1'b0, 1'b0, g, n);
    total++;
    if (n != 16 || g[15:0] !== 16'h0000) begin
      bad++;
      $display("FAIL crc_only: got n=%0d bits=%04h, want 16 0000", n, g[15:0]);
    end
    check_idle_after("crc_only_done_len");
  endtask

  task automatic test_empty();
    logic [63:0] g; int n;
    run_frame(32'h12345678, 6'd0, 1'b0, 1'b0, 1'b0, g, n);
    total++;
    if (n != 0) begin
      bad++;
      $display("FAIL empty_frame: got %0d bits, want 0", n);
    end
    check_idle_after("empty_done_len");
  endtask

  task automatic test_backpressure();
    logic [63:0] g; int n;
    run_frame(32'hA5, 6'd8, 1'b0, 1'b1, 1'b0, g, n);
    total++;
    if (n != 8 || g[7:0] !== 8'hA5) begin
      bad++;
      $display("FAIL backpressure: got n=%0d bits=%02h, want 8 a5", n, g[7:0]);
    end
    check_idle_after("backpressure_done_len");
  endtask

  task automatic test_back_to_back();
    logic [63:0] g; int n;
    run_frame(32'hFFFFFFFF, 6'd40, 1'b0, 1'b0, 1'b0, g, n);
    total++;
    if (n != 32 || g[31:0] !== 32'hFFFFFFFF) begin
      bad++;
      $display("FAIL clamp: got n=%0d bits=%08h, want 32 ffffffff", n, g[31:0]);
    end
    run_frame(32'h1, 6'd1, 1'b0, 1'b0, 1'b0, g, n);
    total++;
    if (n != 1 || g[0] !== 1'b1) begin
      bad++;
      $display("FAIL back_to_back: got n=%0d bit=%b, want 1 1", n, g[0]);
    end
    check_idle_after("b2b_done_len");
  endtask

  task automatic test_abort();
    logic [7:0] d;
    d = 8'($urandom);
    bus.data = {24'h0, d}; bus.len = 6'd8; bus.crc_en = 1; bus.bit_ready = 1; bus.start = 1;
    @(posedge clk); #1 bus.start = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (bus.bit_valid !== 1'b1 || bus.bit_out !== d[7-i]) begin
        bad++;
        $display("FAIL abort_pre_bit[%0d]: got valid=%b bit=%b, want 1 %b",
                 i, bus.bit_valid, bus.bit_out, d[7-i]);
      end
      if (i < 2) begin
        @(posedge clk); #1;
      end
    end
    bus.abort = 1; bus.start = 1; bus.data = 32'hFFFF; bus.len = 6'd16;
    @(posedge clk); #1 bus.abort = 0; bus.start = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (bus.bit_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
        bad++;
        $display("FAIL abort_idle[%0d]: got valid=%b busy=%b done=%b, want 0 0 0",
                 i, bus.bit_valid, bus.busy, bus.done);
      end
    end
  endtask

  task automatic test_busy_start();
    logic [63:0] g; int n;
    run_frame(32'h0000B3C1, 6'd16, 1'b1, 1'b1, 1'b1, g, n);
    total++;
    if (n != 32 || g[31:16] !== 16'hB3C1) begin
      bad++;
      $display("FAIL busy_start: got n=%0d data=%04h, want 32 b3c1", n, g[31:16]);
    end
    check_idle_after("busy_start_done_len");
  endtask

  task automatic test_random();
    logic [63:0] g; int n, want;
    logic [31:0] d; logic [5:0] l; logic c;
    for (int f = 0; f < 12; f++) begin
      d = $urandom;
      l = 6'($urandom_range(0, 40));
      c = 1'($urandom_range(0, 1));
      run_frame(d, l, c, 1'b1, 1'b0, g, n);
      want = ((l > 6'd32) ? 32 : int'(l)) + (c ? 16 : 0);
      total++;
      if (n != want) begin
        bad++;
        $display("FAIL random_count[%0d]: got %0d, want %0d", f, n, want);
      end
    end
    check_idle_after("random_done_len");
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_crc_zero_byte();
    test_crc_only();
    test_empty();
    test_backpressure();
    test_back_to_back();
    test_abort();
    test_busy_start();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
